// File: rtl/iter_shifter.sv
// Multi-cycle WIDTH-bit shifter (SLL/SRL/SRA, optional ROR), one log-shifter stage per clock.
// Define ITER_SHIFTER_ROTATE_EN to build rotate-right for op=11; otherwise op=11 acts as SRL.
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(SHAMT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHAMT_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   work_reg;
  logic [SHAMT_W-1:0] amt_reg;
  logic [1:0]         op_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   stage_out [SHAMT_W];
  logic [WIDTH-1:0]   stage_next;

  // Shift amount only uses the low SHAMT_W bits.
  logic unused_y_hi;
  assign unused_y_hi = ^Y[WIDTH-1:SHAMT_W];

  // Each stage k shifts by the constant 2^k; only the stage selected by cnt_reg is used.
  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
    localparam int S = 1 << gi;
    logic [WIDTH-1:0] shifted;

    always_comb begin
      case (op_reg)
        2'b00:   shifted = work_reg << S;
        2'b10:   shifted = WIDTH'($signed(work_reg) >>> S);
`ifdef ITER_SHIFTER_ROTATE_EN
        2'b11:   shifted = {work_reg[S-1:0], work_reg[WIDTH-1:S]};
`endif
        default: shifted = work_reg >> S;
      endcase
    end

    assign stage_out[gi] = amt_reg[gi] ? shifted : work_reg;
  end

  always_comb begin
    stage_next = work_reg;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (cnt_reg == CNT_W'(k)) stage_next = stage_out[k];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      amt_reg   <= '0;
      op_reg    <= '0;
      cnt_reg   <= '0;
      Z         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          work_reg <= stage_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            Z         <= stage_next;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE gives back-to-back throughput.
          done <= 1'b0;
          if (start) begin
            state_reg <= RUN;
            work_reg  <= X;
            amt_reg   <= Y[SHAMT_W-1:0];
            op_reg    <= op;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
